axis_cube_framer: RTL and testbench
===================================

# axis_cube_framer

Synthesizable AXI-Stream framer that takes a raw stream of image samples and attaches the four hierarchy flags LCPLC consumes: `x_last_r`, `x_last_s`, `x_last_b` and `x_last_i`. The flags are generated from runtime cube dimensions. It sits between any sample source (DMA, file reader, sensor front end) and the `LCPLC` input port, and replaces four separate golden flag streams. It adds a full-throughput registered output stage and an optional compile-time input throttle for stall testing.

## Interface
Parameters:
- DATA_WIDTH, 16, sample width.
- DIM_WIDTH, 12, width of each dimension config port.
- THROTTLE_PERIOD, 4, throttle cycle length in clocks (used only with FRAMER_THROTTLE_EN).
- THROTTLE_ON, 1, accepting cycles per throttle period (used only with FRAMER_THROTTLE_EN).

Ports (one synchronous, active-high reset `rst` on clock `clk`; all state on rising edge of `clk`):
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- cfg_cols  in  DIM_WIDTH  samples per row.
- cfg_rows  in  DIM_WIDTH  rows per slice.
- cfg_bands  in  DIM_WIDTH  slices (bands) per block.
- cfg_blocks  in  DIM_WIDTH  blocks per image.
- input_valid  in  1  source sample valid.
- input_ready  out  1  framer accepts sample.
- input_data  in  DATA_WIDTH  sample.
- x_valid  out  1  framed sample valid.
- x_ready  in  1  LCPLC ready.
- x_data  out  DATA_WIDTH  sample.
- x_last_r, x_last_s, x_last_b, x_last_i  out  1 each  hierarchy flags.
- busy  out  1  high while an image is partially transferred.

## Operation
- Counters: col, row, band, block. Each is DIM_WIDTH wide and starts at 0. Only an accepted input beat (input_valid && input_ready) advances them.
- Flags are computed on the accepted beat and stored alongside the sample:
  - last_r when col==cols-1.
  - last_s when last_r and row==rows-1.
  - last_b when last_s and band==bands-1.
  - last_i when last_b and block==blocks-1.
  - The flags are strictly nested.
- Advance rules:
  - col wraps to 0 on last_r, and row increments.
  - row wraps on last_s, and band increments.
  - band wraps on last_b, and block increments.
  - block wraps on last_i, and all counters return to 0.
- Dimensions are latched into shadow registers on the first accepted beat of each image, i.e. when all counters are 0. Changes on cfg_* during an image are ignored until the next image.
- A cfg value of 0 is treated as 1.
- busy: set on the first accepted beat; cleared on the beat carrying last_i. If an image is a single sample, busy stays 0.
- Output stage is a 2-entry skid buffer holding {data, 4 flags}.

## Timing
- Reset values: x_valid=0, x_data=0, all x_last_*=0, busy=0, input_ready=0 during reset, counters 0, shadow dims 1.
- input_ready rises the cycle after rst deasserts.
- Latency is 1 clock from accepted input beat to x_valid.
- Sustains 1 beat/clock when x_ready is held high.
- AXIS rules:
  - x_valid, once high, holds with stable data and flags until x_ready.
  - input_ready does not depend combinationally on x_ready; it is registered, driven from skid occupancy < 2.
- Buffer full (2 entries): input_ready=0. Buffer empty: x_valid=0.
- Simultaneous push and pop keeps occupancy unchanged with no bubble.
- Reset mid-image flushes the buffer, zeroes the counters, and drops the partial image. No flags are emitted for it.

## Configuration
- FRAMER_THROTTLE_EN defined:
  - A free-running phase counter 0..THROTTLE_PERIOD-1 gates acceptance: input_ready = skid_ready && (phase < THROTTLE_ON).
  - Throttle occupies the input side only, so output AXIS rules hold.
  - Phase resets to 0 with rst.
- Undefined: no phase counter, no gating; THROTTLE_* parameters are ignored.

## Structure
- Package `lcplc_stream_pkg`:
  - `cube_dims_t`, a struct of the four DIM_WIDTH dims.
  - `hier_flags_t`, a packed struct {r, s, b, i}.
  - localparam FLAG_COUNT=4.
- Sub-module `axis_skid_buffer`, parametrised by payload width (DATA_WIDTH+4). It is reusable elsewhere in the codebase.
- Counters, flag logic, shadow dims and throttle live in the top module.

## Test plan
- Dims cols=4, rows=2, bands=3, blocks=2, x_ready=1, 48 samples 0..47:
  - last_r on samples 3,7,…,47 (12 beats).
  - last_s on 7,15,…,47 (6).
  - last_b on 23,47.
  - last_i on 47 only.
  - Data passes unchanged.
  - One beat per clock after 1-cycle latency.
- Same stream with x_ready toggling 1-in-3:
  - The identical flag/data sequence is observed.
  - x_valid/x_data are never retracted while stalled.
  - input_ready drops when 2 entries are held.
- cfg_cols changed from 4 to 8 at sample 10:
  - The first image keeps 4-column framing.
  - The next image uses 8 columns (last_r at its sample 7).
- Reset asserted at sample 20 of the first image, then 48 fresh samples:
  - Outputs go to 0 in the cycle after rst.
  - The new image is framed from col 0, with last_i on its sample 47.
- All cfg = 0:
  - Every sample carries all four flags set.
  - busy stays 0.
- With FRAMER_THROTTLE_EN, PERIOD=4, ON=1, x_ready=1:
  - Exactly one accepted beat per 4 clocks.
  - Flag positions are unchanged.

Source files
------------

// File: rtl/lcplc_stream_pkg.sv
// Shared types for the LCPLC sample-stream front end: cube dimensions,
// hierarchy flags and the skid-buffer occupancy states.
package lcplc_stream_pkg;

  localparam int CUBE_DIM_WIDTH = 12;
  localparam int FLAG_COUNT     = 4;

  typedef logic [CUBE_DIM_WIDTH-1:0] dim_t;

  localparam dim_t DIM_ONE = dim_t'(1);

  // Runtime cube geometry, one field per hierarchy level.
  typedef struct packed {
    dim_t cols;
    dim_t rows;
    dim_t bands;
    dim_t blocks;
  } cube_dims_t;

  // End-of-row / slice / block / image markers, strictly nested (i implies b implies s implies r).
  typedef struct packed {
    logic r;
    logic s;
    logic b;
    logic i;
  } hier_flags_t;

  // Occupancy of a two-entry skid buffer.
  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_FULL  = 2'd2
  } skid_state_t;

  // A zero dimension is meaningless, so it is read as a single element.
  function automatic dim_t dim_or_one(input dim_t d);
    return (d == '0) ? DIM_ONE : d;
  endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry AXI-Stream skid buffer with fully registered outputs.
// in_ready is a flop driven from the next occupancy, so it never depends
// combinationally on out_ready. Push and pop in the same cycle keep one
// entry in flight with no bubble, giving one beat per clock.
module axis_skid_buffer
  import lcplc_stream_pkg::*;
#(
  parameter int WIDTH = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_payload,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_payload
);

  skid_state_t      state_q, state_d;
  logic             ready_q;
  logic [WIDTH-1:0] head_q;
  logic [WIDTH-1:0] skid_q;
  logic             push, pop;
  logic             load_head_in, load_head_skid, load_skid;

  assign push = in_valid && ready_q;
  assign pop  = (state_q != SKID_EMPTY) && out_ready;

  // State register: occupancy plus the registered ready it implies.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments here so every flop samples pre-edge values, regardless of block order.
    if (rst) begin
      state_q <= SKID_EMPTY;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d != SKID_FULL);
    end
  end

  // Next-state logic: occupancy transitions and which register loads what.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latches).
    state_d        = state_q;
    load_head_in   = 1'b0;
    load_head_skid = 1'b0;
    load_skid      = 1'b0;
    unique case (state_q)
      SKID_EMPTY: begin
        if (push) begin
          state_d      = SKID_ONE;
          load_head_in = 1'b1;
        end
      end
      SKID_ONE: begin
        if (push && !pop) begin
          state_d   = SKID_FULL;
          load_skid = 1'b1;
        end else if (push && pop) begin
          load_head_in = 1'b1;
        end else if (pop) begin
          state_d = SKID_EMPTY;
        end
      end
      SKID_FULL: begin
        // ready_q is low while full, so only a pop can happen here.
        if (pop) begin
          state_d        = SKID_ONE;
          load_head_skid = 1'b1;
        end
      end
      default: state_d = SKID_EMPTY;
    endcase
  end

  // Output logic: the head register is the AXIS output, valid whenever occupied.
  always_comb begin
    out_valid   = (state_q != SKID_EMPTY);
    out_payload = head_q;
    in_ready    = ready_q;
  end

  // Head register: cleared on reset so the visible output reads zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
    end else if (load_head_in) begin
      head_q <= in_payload;
    end else if (load_head_skid) begin
      head_q <= skid_q;
    end
  end

  // Skid register: holds the second entry while the consumer stalls.
  always_ff @(posedge clk) begin
    // NOTE: storage that is never observed before being written needs no reset; occupancy guards it.
    if (load_skid) begin
      skid_q <= in_payload;
    end
  end

endmodule

// File: rtl/axis_cube_framer.sv
// AXI-Stream cube framer: tags each accepted sample with end-of-row, slice,
// block and image flags derived from runtime cube dimensions, then forwards
// {data, flags} through a two-entry registered skid buffer.
// Optional input throttle for stall testing: define FRAMER_THROTTLE_EN.
module axis_cube_framer
  import lcplc_stream_pkg::*;
#(
  parameter int DATA_WIDTH      = 16,
  parameter int DIM_WIDTH       = CUBE_DIM_WIDTH,
  parameter int THROTTLE_PERIOD = 4,
  parameter int THROTTLE_ON     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DIM_WIDTH-1:0]  cfg_cols,
  input  logic [DIM_WIDTH-1:0]  cfg_rows,
  input  logic [DIM_WIDTH-1:0]  cfg_bands,
  input  logic [DIM_WIDTH-1:0]  cfg_blocks,
  input  logic                  input_valid,
  output logic                  input_ready,
  input  logic [DATA_WIDTH-1:0] input_data,
  output logic                  x_valid,
  input  logic                  x_ready,
  output logic [DATA_WIDTH-1:0] x_data,
  output logic                  x_last_r,
  output logic                  x_last_s,
  output logic                  x_last_b,
  output logic                  x_last_i,
  output logic                  busy
);

  localparam int PAYLOAD_WIDTH = DATA_WIDTH + FLAG_COUNT;

  logic                     skid_ready;
  logic                     throttle_open;
  logic                     accept;
  logic                     first_beat;
  logic [DIM_WIDTH-1:0]     col_q, row_q, band_q, block_q;
  cube_dims_t               cfg_dims, shadow_q, dims;
  hier_flags_t              flags, out_flags;
  logic [PAYLOAD_WIDTH-1:0] out_payload;
  logic                     busy_q;

  assign input_ready = skid_ready && throttle_open;
  assign accept      = input_valid && input_ready;

`ifdef FRAMER_THROTTLE_EN
  localparam int PHASE_WIDTH = (THROTTLE_PERIOD > 1) ? $clog2(THROTTLE_PERIOD) : 1;

  logic [PHASE_WIDTH-1:0] phase_q;

  // Free-running throttle phase, 0 .. THROTTLE_PERIOD-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= '0;
    end else if (phase_q == PHASE_WIDTH'(THROTTLE_PERIOD - 1)) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_q + 1'b1;
    end
  end

  assign throttle_open = (int'(phase_q) < THROTTLE_ON);
`else
  assign throttle_open = 1'b1;
`endif

  // Dimension selection and flag generation for the beat on the input.
  always_comb begin
    cfg_dims.cols   = dim_or_one(cfg_cols);
    cfg_dims.rows   = dim_or_one(cfg_rows);
    cfg_dims.bands  = dim_or_one(cfg_bands);
    cfg_dims.blocks = dim_or_one(cfg_blocks);

    // The first beat of an image uses the live config, since the shadow
    // registers only capture it on that same edge.
    first_beat = (col_q == '0) && (row_q == '0) && (band_q == '0) && (block_q == '0);
    dims       = first_beat ? cfg_dims : shadow_q;

    flags.r = (col_q == dims.cols - DIM_ONE);
    flags.s = flags.r && (row_q == dims.rows - DIM_ONE);
    flags.b = flags.s && (band_q == dims.bands - DIM_ONE);
    flags.i = flags.b && (block_q == dims.blocks - DIM_ONE);
  end

  // Shadow dimensions: frozen for the whole image once its first beat is taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q <= '{cols: DIM_ONE, rows: DIM_ONE, bands: DIM_ONE, blocks: DIM_ONE};
    end else if (accept && first_beat) begin
      shadow_q <= cfg_dims;
    end
  end

  // Position counters: advance per accepted beat, wrapping at each hierarchy level.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q   <= '0;
      row_q   <= '0;
      band_q  <= '0;
      block_q <= '0;
    end else if (accept) begin
      if (flags.i) begin
        col_q   <= '0;
        row_q   <= '0;
        band_q  <= '0;
        block_q <= '0;
      end else if (flags.b) begin
        col_q   <= '0;
        row_q   <= '0;
        band_q  <= '0;
        block_q <= block_q + DIM_ONE;
      end else if (flags.s) begin
        col_q  <= '0;
        row_q  <= '0;
        band_q <= band_q + DIM_ONE;
      end else if (flags.r) begin
        col_q <= '0;
        row_q <= row_q + DIM_ONE;
      end else begin
        col_q <= col_q + DIM_ONE;
      end
    end
  end

  // Image-in-progress flag: every accepted beat except the image's last leaves it set.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
    end else if (accept) begin
      busy_q <= !flags.i;
    end
  end

  assign busy = busy_q;

  axis_skid_buffer #(
    .WIDTH (PAYLOAD_WIDTH)
  ) u_skid (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (input_valid && throttle_open),
    .in_ready    (skid_ready),
    .in_payload  ({input_data, flags}),
    .out_valid   (x_valid),
    .out_ready   (x_ready),
    .out_payload (out_payload)
  );

  assign {x_data, out_flags} = out_payload;
  assign x_last_r = out_flags.r;
  assign x_last_s = out_flags.s;
  assign x_last_b = out_flags.b;
  assign x_last_i = out_flags.i;

endmodule

// File: tb/tb_axis_cube_framer.sv
// Directed bench for axis_cube_framer. Expected {data, flags} come from an
// arithmetic model of the cube position (modulo of the sample index), queued
// per beat and compared as beats leave the DUT.
module tb_axis_cube_framer;

  localparam int DW   = 16;
  localparam int DIMW = 12;
`ifdef FRAMER_THROTTLE_EN
  localparam int SPACING = 4;
`else
  localparam int SPACING = 1;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [DIMW-1:0] cfg_cols = 12'd4, cfg_rows = 12'd2, cfg_bands = 12'd3, cfg_blocks = 12'd2;
  logic            input_valid = 1'b0;
  logic            input_ready;
  logic [DW-1:0]   input_data = '0;
  logic            x_valid;
  logic            x_ready = 1'b1;
  logic [DW-1:0]   x_data;
  logic            x_last_r, x_last_s, x_last_b, x_last_i;
  logic            busy;

  axis_cube_framer #(
    .DATA_WIDTH      (DW),
    .DIM_WIDTH       (DIMW),
    .THROTTLE_PERIOD (4),
    .THROTTLE_ON     (1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_cols    (cfg_cols),
    .cfg_rows    (cfg_rows),
    .cfg_bands   (cfg_bands),
    .cfg_blocks  (cfg_blocks),
    .input_valid (input_valid),
    .input_ready (input_ready),
    .input_data  (input_data),
    .x_valid     (x_valid),
    .x_ready     (x_ready),
    .x_data      (x_data),
    .x_last_r    (x_last_r),
    .x_last_s    (x_last_s),
    .x_last_b    (x_last_b),
    .x_last_i    (x_last_i),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Expected beat for sample n of an image with dims c x r x b x k.
  function automatic logic [DW+3:0] model_beat(input int n, input int d,
                                                input int c, input int r, input int b, input int k);
    int slice = c * r;
    int blk   = c * r * b;
    int img   = c * r * b * k;
    return {d[DW-1:0], (n % c) == c - 1, (n % slice) == slice - 1, (n % blk) == blk - 1, n == img - 1};
  endfunction

  logic [DW+3:0] exp_q[$];
  bit            stall_mode  = 1'b0;
  bit            ready_force = 1'b1;
  bit            saw_full    = 1'b0;
  bit            prev_stall  = 1'b0;
  logic [DW+3:0] prev_pl;
  logic [DW+3:0] mon_pl;
  int            acc_count = 0, acc_first = 0, acc_last = 0;
  int            busy_hi = 0;

  // Consumer ready: 1-in-3 while stalling, otherwise the level the test asks for.
  always @(posedge clk) begin
    #2;
    x_ready = stall_mode ? (cyc % 3 == 0) : ready_force;
  end

  // Output monitor: sampled mid-cycle, so a handshake seen here completes on the next edge.
  always @(negedge clk) begin
    mon_pl = {x_data, x_last_r, x_last_s, x_last_b, x_last_i};
    if (!rst) begin
      if (prev_stall) begin
        check("hold_valid", x_valid, 1);
        check("hold_payload", mon_pl, prev_pl);
      end
      if (x_valid && x_ready) begin
        if (exp_q.size() == 0) check("unexpected_beat", exp_q.size(), 1);
        else check("beat", mon_pl, exp_q.pop_front());
      end
      if (input_valid && input_ready) begin
        if (acc_count == 0) acc_first = cyc;
        acc_last = cyc;
        acc_count++;
      end
      if (stall_mode && x_valid && !input_ready) saw_full = 1'b1;
      if (busy) busy_hi++;
      prev_stall = x_valid && !x_ready;
      prev_pl    = mon_pl;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // Offer one sample and return just after the edge that accepts it.
  task automatic send_beat(input int d);
    int guard = 0;
    input_valid = 1'b1;
    input_data  = d[DW-1:0];
    @(negedge clk);
    while (!input_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!input_ready) check("ready_timeout", input_ready, 1);
    @(posedge clk);
    #1;
    input_valid = 1'b0;
  endtask

  task automatic send_image(input int n, input int base, input int c, input int r, input int b, input int k);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(model_beat(i, base + i, c, r, b, k));
      send_beat(base + i);
    end
  endtask

  task automatic drain(input string tag);
    int guard = 0;
    while (exp_q.size() != 0 && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    repeat (2) @(negedge clk);
    check({"drain_", tag}, exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_x_valid"}, x_valid, 0);
    check({tag, "_x_data"}, x_data, 0);
    check({tag, "_flags"}, {x_last_r, x_last_s, x_last_b, x_last_i}, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_input_ready"}, input_ready, 0);
  endtask

  initial begin
    // Reset state and ready release.
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    rst = 1'b0;
    check("ready_at_release", input_ready, 0);
    @(posedge clk);
    #1;
    check("ready_rise", input_ready, (SPACING == 1));

    // 4x2x3x2 cube, consumer always ready.
    acc_count = 0;
    for (int i = 0; i < 48; i++) begin
      exp_q.push_back(model_beat(i, i, 4, 2, 3, 2));
      send_beat(i);
      if (i == 0) begin
        check("latency_valid", x_valid, 1);
        check("latency_data", x_data, 0);
        check("busy_first", busy, 1);
      end
    end
    check("busy_end", busy, 0);
    drain("full_rate");
    check("accept_count", acc_count, 48);
    check("accept_span", acc_last - acc_first, 47 * SPACING);

    // Same cube, consumer ready one cycle in three.
    stall_mode = 1'b1;
    saw_full   = 1'b0;
    send_image(48, 100, 4, 2, 3, 2);
    drain("stalled");
    stall_mode = 1'b0;
`ifndef FRAMER_THROTTLE_EN
    check("ready_drops_when_full", saw_full, 1);
`endif

    // cfg_cols moves 4 -> 8 mid-image; only the following image sees it.
    for (int i = 0; i < 48; i++) begin
      if (i == 10) cfg_cols = 12'd8;
      exp_q.push_back(model_beat(i, 200 + i, 4, 2, 3, 2));
      send_beat(200 + i);
    end
    send_image(96, 300, 8, 2, 3, 2);
    drain("cfg_change");
    cfg_cols = 12'd4;

    // Reset part-way through an image with two beats held in the buffer.
    for (int i = 0; i < 20; i++) begin
      exp_q.push_back(model_beat(i, 500 + i, 4, 2, 3, 2));
      send_beat(500 + i);
    end
    drain("pre_reset");
    ready_force = 1'b0;
    @(posedge clk);
    #1;
    send_beat(520);
    send_beat(521);
    check("busy_mid_image", busy, 1);
    check("held_valid", x_valid, 1);
    check("held_data", x_data, 16'd520);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_reset_outputs("mid_rst");
    rst = 1'b0;
    ready_force = 1'b1;
    send_image(48, 600, 4, 2, 3, 2);
    check("busy_after_fresh", busy, 0);
    drain("post_reset");

    // All dimensions zero: every sample is its own image.
    cfg_cols   = '0;
    cfg_rows   = '0;
    cfg_bands  = '0;
    cfg_blocks = '0;
    busy_hi    = 0;
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(model_beat(0, 700 + i, 1, 1, 1, 1));
      send_beat(700 + i);
    end
    drain("zero_dims");
    check("zero_dims_busy", busy_hi, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
